clock_set_controller: RTL

CLOCK_SET_CONTROLLER -- requirements
Module: clock_set_controller

---
 rtl/clock_set_controller.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/clock_set_controller.sv
// Clock-set controller: button edge detection, edit-cursor FSM, idle timeout and edit blink.
// Define CLOCK_SET_AUTOREPEAT_EN to auto-repeat a held Up/Down button while editing.
module clock_set_controller #(
    parameter int unsigned REPEAT_DELAY  = 50000000,
    parameter int unsigned REPEAT_PERIOD = 10000000,
    parameter int unsigned IDLE_TIMEOUT  = 1000000000,
    parameter int unsigned BLINK_HALF    = 25000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btnMode,
    input  logic       btnUp,
    input  logic       btnDown,
    input  logic       btnClear,
    output logic [2:0] cursorPos,
    output logic       up,
    output logic       down,
    output logic       clearPulse,
    output logic       editing,
    output logic       blink
);

    // State codes double as the cursor encoding so cursorPos is the state register itself.
    localparam logic [2:0] StRun      = 3'b000;
    localparam logic [2:0] StEditHour = 3'b100;
    localparam logic [2:0] StEditMin  = 3'b010;
    localparam logic [2:0] StEditSec  = 3'b001;

    localparam int unsigned IdleW  = (IDLE_TIMEOUT > 1) ? $clog2(IDLE_TIMEOUT) : 1;
    localparam int unsigned BlinkW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam logic [IdleW-1:0]  IdleLast  = IdleW'(IDLE_TIMEOUT - 1);
    localparam logic [BlinkW-1:0] BlinkLast = BlinkW'(BLINK_HALF - 1);

    logic [2:0]        state_q, state_d, mode_next;
    logic              mode_prev_q, up_prev_q, down_prev_q, clear_prev_q;
    logic              up_q, up_d, down_q, down_d, clear_q, clear_d;
    logic [IdleW-1:0]  idle_q, idle_d;
    logic [BlinkW-1:0] blink_cnt_q, blink_cnt_d;
    logic              blink_q, blink_d;

    logic mode_edge, up_edge, down_edge, clear_edge, any_edge;
    logic in_edit, cmd_ok, step_up, step_dn;
    logic rep_fire, rep_up, rep_dn, activity;

    assign mode_edge  = btnMode & ~mode_prev_q;
    assign up_edge    = btnUp & ~up_prev_q;
    assign down_edge  = btnDown & ~down_prev_q;
    assign clear_edge = btnClear & ~clear_prev_q;
    assign any_edge   = mode_edge | up_edge | down_edge | clear_edge;

    assign in_edit = (state_q != StRun);
    // Up/Down act only in edit and yield to Clear and Mode edges in the same cycle.
    assign cmd_ok  = in_edit & ~clear_edge & ~mode_edge;
    assign step_up = cmd_ok & up_edge & ~btnDown;
    assign step_dn = cmd_ok & down_edge & ~btnUp;

`ifdef CLOCK_SET_AUTOREPEAT_EN
    localparam int unsigned RepMax = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned RepW   = (RepMax > 1) ? $clog2(RepMax) : 1;
    localparam logic [RepW-1:0] RepDelayLast  = RepW'(REPEAT_DELAY - 1);
    localparam logic [RepW-1:0] RepPeriodLast = RepW'(REPEAT_PERIOD - 1);

    logic [RepW-1:0] rep_cnt_q, rep_cnt_d, rep_last;
    logic            rep_active_q, rep_active_d, rep_period_q, rep_period_d;
    logic            rep_hold;

    assign rep_hold = cmd_ok & (btnUp ^ btnDown);
    assign rep_last = rep_period_q ? RepPeriodLast : RepDelayLast;

    // Armed only by a pulse-producing press; any break in a lone hold disarms until re-press.
    always_comb begin
        rep_cnt_d    = rep_cnt_q;
        rep_active_d = rep_active_q;
        rep_period_d = rep_period_q;
        rep_fire     = 1'b0;
        if (step_up || step_dn) begin
            rep_active_d = 1'b1;
            rep_period_d = 1'b0;
            rep_cnt_d    = '0;
        end else if (rep_active_q && rep_hold) begin
            if (rep_cnt_q == rep_last) begin
                rep_fire     = 1'b1;
                rep_period_d = 1'b1;
                rep_cnt_d    = '0;
            end else begin
                rep_cnt_d = rep_cnt_q + 1'b1;
            end
        end else begin
            rep_active_d = 1'b0;
            rep_period_d = 1'b0;
            rep_cnt_d    = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rep_cnt_q    <= '0;
            rep_active_q <= 1'b0;
            rep_period_q <= 1'b0;
        end else begin
            rep_cnt_q    <= rep_cnt_d;
            rep_active_q <= rep_active_d;
            rep_period_q <= rep_period_d;
        end
    end
`else
    assign rep_fire = 1'b0;
`endif

    assign rep_up   = rep_fire & btnUp;
    assign rep_dn   = rep_fire & btnDown;
    assign activity = any_edge | rep_fire;

    always_comb begin
        case (state_q)
            StRun:      mode_next = StEditHour;
            StEditHour: mode_next = StEditMin;
            StEditMin:  mode_next = StEditSec;
            default:    mode_next = StRun;
        endcase
    end

    always_comb begin
        state_d = state_q;
        if (clear_edge) begin
            state_d = StRun;
        end else if (mode_edge) begin
            state_d = mode_next;
        end else if (in_edit && !activity && idle_q == IdleLast) begin
            state_d = StRun;
        end
    end

    always_comb begin
        if (state_d == StRun || activity) begin
            idle_d = '0;
        end else begin
            idle_d = idle_q + 1'b1;
        end
    end

    // Blink restarts high on every entry into an edit field, including field-to-field steps.
    always_comb begin
        blink_d     = blink_q;
        blink_cnt_d = blink_cnt_q;
        if (state_d == StRun || state_d != state_q) begin
            blink_d     = 1'b1;
            blink_cnt_d = '0;
        end else if (blink_cnt_q == BlinkLast) begin
            blink_d     = ~blink_q;
            blink_cnt_d = '0;
        end else begin
            blink_cnt_d = blink_cnt_q + 1'b1;
        end
    end

    assign up_d    = step_up | rep_up;
    assign down_d  = step_dn | rep_dn;
    assign clear_d = clear_edge;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StRun;
            mode_prev_q  <= 1'b0;
            up_prev_q    <= 1'b0;
            down_prev_q  <= 1'b0;
            clear_prev_q <= 1'b0;
            up_q         <= 1'b0;
            down_q       <= 1'b0;
            clear_q      <= 1'b0;
            idle_q       <= '0;
            blink_cnt_q  <= '0;
            blink_q      <= 1'b1;
        end else begin
            state_q      <= state_d;
            mode_prev_q  <= btnMode;
            up_prev_q    <= btnUp;
            down_prev_q  <= btnDown;
            clear_prev_q <= btnClear;
            up_q         <= up_d;
            down_q       <= down_d;
            clear_q      <= clear_d;
            idle_q       <= idle_d;
            blink_cnt_q  <= blink_cnt_d;
            blink_q      <= blink_d;
        end
    end

    assign cursorPos  = state_q;
    assign editing    = (state_q != StRun);
    assign up         = up_q;
    assign down       = down_q;
    assign clearPulse = clear_q;
    assign blink      = blink_q;

endmodule
